// File: rtl/seq_count_ctrl.sv
// Start-armed up-counter with latched terminal value, pause state and x-stall timeout.
// Optional AUTO_RESTART_EN: reload to 0 at terminal count and keep running instead of stopping.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for s; count, g, err hold their last values
// RUN   | counting on every cycle x is high
// PAUSE | x went low; counting the stall towards the timeout abort
module seq_count_ctrl #(
  parameter int WIDTH    = 4,
  parameter int TIMEOUT  = 4,
  parameter int TO_WIDTH = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             s,
  input  logic             x,
  input  logic [WIDTH-1:0] term,
  output logic [WIDTH-1:0] count,
  output logic             g,
  output logic             err,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  // to_cnt reaching TIMEOUT-1 in PAUSE means this x-low edge is the TIMEOUT-th one
  localparam logic [TO_WIDTH-1:0] TO_END = TO_WIDTH'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    count_d, term_q, term_d;
  logic                g_d, err_d;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_d;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      count   <= '0;
      g       <= 1'b0;
      err     <= 1'b0;
      term_q  <= '0;
      to_cnt  <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
      g       <= g_d;
      err     <= err_d;
      term_q  <= term_d;
      to_cnt  <= to_cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count;
    g_d      = g;
    err_d    = err;
    term_d   = term_q;
    to_cnt_d = to_cnt;
    case (state_q)
      IDLE: begin
        if (s) begin
          count_d  = '0;
          g_d      = 1'b0;
          err_d    = 1'b0;
          term_d   = term;
          to_cnt_d = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (count == term_q) begin
          g_d = 1'b1;
`ifdef AUTO_RESTART_EN
          count_d = '0;
`else
          state_d = IDLE;
`endif
        end else begin
`ifdef AUTO_RESTART_EN
          g_d = 1'b0;
`endif
          if (x) begin
            count_d = count + 1'b1;
          end else begin
            to_cnt_d = TO_WIDTH'(1);
            state_d  = PAUSE;
          end
        end
      end
      PAUSE: begin
`ifdef AUTO_RESTART_EN
        g_d = 1'b0;
`endif
        if (x) begin
          count_d  = count + 1'b1;
          to_cnt_d = '0;
          state_d  = RUN;
        end else if (to_cnt == TO_END) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign state = state_q;

endmodule

// File: tb/tb_seq_count_ctrl.sv
// Scoreboard bench for seq_count_ctrl: a cycle model pushes expected outputs per driven cycle,
// which are popped and compared one cycle later against the DUT.
module tb_seq_count_ctrl;

  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             clear, s, x;
  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] count;
  logic             g, err, busy;
  logic [1:0]       state;

  seq_count_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TO_WIDTH(3)) dut (
    .clk   (clk),
    .clear (clear),
    .s     (s),
    .x     (x),
    .term  (term),
    .count (count),
    .g     (g),
    .err   (err),
    .busy  (busy),
    .state (state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] count;
    logic             g;
    logic             err;
    logic             busy;
    logic [1:0]       state;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  logic [1:0]       m_state;
  logic [WIDTH-1:0] m_count, m_term;
  logic             m_g, m_err;
  int               m_to;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_step(input logic c, input logic s_i, input logic x_i, input logic [WIDTH-1:0] t);
    if (c) begin
      m_state = 2'b00; m_count = '0; m_g = 1'b0; m_err = 1'b0; m_term = '0; m_to = 0;
    end else begin
      case (m_state)
        2'b00: if (s_i) begin
          m_count = '0; m_g = 1'b0; m_err = 1'b0; m_term = t; m_to = 0; m_state = 2'b01;
        end
        2'b01: begin
          if (m_count == m_term) begin
            m_g = 1'b1;
`ifdef AUTO_RESTART_EN
            m_count = '0;
`else
            m_state = 2'b00;
`endif
          end else begin
`ifdef AUTO_RESTART_EN
            m_g = 1'b0;
`endif
            if (x_i) m_count = m_count + 1'b1;
            else begin
              m_to = 1; m_state = 2'b10;
            end
          end
        end
        2'b10: begin
`ifdef AUTO_RESTART_EN
          m_g = 1'b0;
`endif
          if (x_i) begin
            m_count = m_count + 1'b1; m_to = 0; m_state = 2'b01;
          end else if (m_to + 1 == TIMEOUT) begin
            m_err = 1'b1; m_state = 2'b00;
          end else m_to = m_to + 1;
        end
        default: m_state = 2'b00;
      endcase
    end
  endtask

  task automatic tick(input string tag, input logic c, input logic s_i, input logic x_i,
                      input logic [WIDTH-1:0] t);
    exp_t e;
    clear = c; s = s_i; x = x_i; term = t;
    model_step(c, s_i, x_i, t);
    exp_q.push_back({m_count, m_g, m_err, m_state != 2'b00, m_state});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_count"}, 32'(count), 32'(e.count));
    check({tag, "_g"},     32'(g),     32'(e.g));
    check({tag, "_err"},   32'(err),   32'(e.err));
    check({tag, "_busy"},  32'(busy),  32'(e.busy));
    check({tag, "_state"}, 32'(state), 32'(e.state));
  endtask

  initial begin
    m_state = 2'b00; m_count = '0; m_term = '0; m_g = 1'b0; m_err = 1'b0; m_to = 0;
    clear = 1'b1; s = 1'b0; x = 1'b0; term = '0;

    tick("reset", 1, 0, 0, 4'd0);
    check("reset_count", 32'(count), 0);
    check("reset_state", 32'(state), 0);

`ifndef AUTO_RESTART_EN
    // full-range run; term input wanders after start and must be ignored
    tick("t1_start", 0, 1, 1, 4'd15);
    for (int i = 0; i < 16; i++) tick("t1_run", 0, 0, 1, 4'($urandom_range(0, 15)));
    check("t1_count_hold", 32'(count), 15);
    check("t1_g", 32'(g), 1);
    check("t1_busy", 32'(busy), 0);

    tick("t2_start", 0, 1, 1, 4'd3);
    tick("t2_run", 0, 0, 1, 4'd0);
    tick("t2_low", 0, 0, 0, 4'd0);
    check("t2_pause_state", 32'(state), 2);
    tick("t2_low", 0, 0, 0, 4'd0);
    check("t2_pause_count", 32'(count), 1);
    for (int i = 0; i < 3; i++) tick("t2_run", 0, 0, 1, 4'd0);
    check("t2_g", 32'(g), 1);
    check("t2_err", 32'(err), 0);
    check("t2_count", 32'(count), 3);

    tick("t3_start", 0, 1, 1, 4'd9);
    tick("t3_run", 0, 0, 1, 4'd0);
    tick("t3_run", 0, 0, 1, 4'd0);
    for (int i = 0; i < 3; i++) tick("t3_low", 0, 0, 0, 4'd0);
    check("t3_err_early", 32'(err), 0);
    tick("t3_low4", 0, 0, 0, 4'd0);
    check("t3_err", 32'(err), 1);
    check("t3_state", 32'(state), 0);
    check("t3_count", 32'(count), 2);
    check("t3_g", 32'(g), 0);
    tick("t3_restart", 0, 1, 1, 4'd5);
    check("t3_err_cleared", 32'(err), 0);
    for (int i = 0; i < 7; i++) tick("t3_finish", 0, 0, 1, 4'd0);

    tick("t4_start", 0, 1, 1, 4'd0);
    check("t4_busy", 32'(busy), 1);
    check("t4_count", 32'(count), 0);
    tick("t4_s_busy", 0, 1, 1, 4'd7);
    check("t4_g", 32'(g), 1);
    check("t4_busy_done", 32'(busy), 0);
    check("t4_no_restart", 32'(state), 0);

    tick("t5_start", 0, 1, 1, 4'd9);
    for (int i = 0; i < 5; i++) tick("t5_run", 0, 0, 1, 4'd9);
    check("t5_count5", 32'(count), 5);
    tick("t5_clear", 1, 1, 1, 4'd9);
    check("t5_count", 32'(count), 0);
    check("t5_state", 32'(state), 0);
    check("t5_busy", 32'(busy), 0);
`else
    tick("t6_start", 0, 1, 1, 4'd2);
    for (int i = 0; i < 9; i++) begin
      tick("t6_run", 0, 0, 1, 4'd0);
      check("t6_busy", 32'(busy), 1);
      check("t6_g", 32'(g), 32'((i % 3) == 2));
    end
    tick("t6_clear", 1, 0, 0, 4'd0);
`endif

    for (int i = 0; i < 400; i++)
      tick("rand", ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
